main_memory_port: RTL and testbench
===================================

Name: main_memory_port

Overview:
- Main-memory side of the cache controller: a wait-stated memory that the cache controller's memory strobe/read-write outputs drive.
- Captures one request per strobe, holds it for a programmable number of wait cycles, then performs the array read or write.
- Signals completion with a one-cycle ready pulse so the controller's ReadMem/WriteMem states can be checked against real memory timing.
- Sits directly downstream of the cache controller, between it and the backing storage array.

Parameters:
DATA_W, 32, width of the data bus and of each memory word
ADDR_W, 16, width of the request address
DEPTH_LOG2, 10, log2 of the number of words in the array; ADDR_W >= DEPTH_LOG2
WAIT_CYCLES, 4, wait cycles between request capture and array access; legal range 0..255

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
MStrobe  input  1  request strobe; sampled only in IDLE
MRW  input  1  1 = write, 0 = read
MAddr  input  ADDR_W  word address; only the low DEPTH_LOG2 bits index the array
MDataIn  input  DATA_W  write data, captured with the request
MDataOut  output  DATA_W  registered read data
MReady  output  1  one-cycle completion pulse
Busy  output  1  high whenever the state is not IDLE
ProtoErr  output  1  sticky: a strobe arrived while not IDLE

Behaviour:
- Reset (asynchronous, active-high) forces: state IDLE, counter 0, MDataOut 0, MReady 0, Busy 0, ProtoErr 0.
- Reset does not clear the array. Contents are undefined until written; benches must write before reading.
- Reset mid-operation aborts the request. A pending write is not committed; MReady does not pulse.
- State machine has three states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with MStrobe=1: latch MRW, the low DEPTH_LOG2 bits of MAddr, and MDataIn; load the counter with WAIT_CYCLES; go to WAIT.
  - On an edge with MStrobe=0: stay in IDLE.
- WAIT:
  - On an edge with counter != 0: decrement the counter and stay in WAIT.
  - On an edge with counter == 0: perform the access and go to DONE.
    - Write: array[addr] <= latched data.
    - Read: MDataOut <= array[addr].
- DONE:
  - MReady=1 for this single cycle only.
  - Next edge goes unconditionally to IDLE.
- Latency: strobe captured at edge E; access at edge E+WAIT_CYCLES+1; MReady high between edges E+WAIT_CYCLES+1 and E+WAIT_CYCLES+2. With WAIT_CYCLES=4, MReady is high in the 6th cycle after capture.
- WAIT_CYCLES=0: access occurs on the edge immediately after capture.
- Earliest next capture is the edge that leaves DONE plus one: back-to-back requests need one IDLE cycle. A strobe held high continuously is captured again on the first edge in IDLE.
- MStrobe=1 sampled in WAIT or DONE:
  - The strobe is ignored; the in-flight request and its latched fields are unchanged.
  - ProtoErr is set and stays 1 until reset.
- Latched fields are stable for the whole request. MRW, MAddr and MDataIn may change freely after capture.
- MDataOut changes only on a read access. It holds its last read value through writes and idle periods.
- Address aliasing: MAddr bits above DEPTH_LOG2 are ignored. For example, 0x0405 and 0x0005 hit the same word when DEPTH_LOG2=10.
- Busy is combinational from state; MReady is a decode of DONE. Both are glitch-free relative to clk.
- Read-after-write to the same address in consecutive requests returns the newly written value.

Test Plan:
- Reset, then write: strobe MRW=1, MAddr=0x0010, MDataIn=0xDEADBEEF with WAIT_CYCLES=4 -> Busy=1 for 6 cycles; MReady pulses once in cycle 6; MDataOut stays 0.
- Read of that word: MRW=0, MAddr=0x0010 -> MReady in cycle 6 after capture; MDataOut=0xDEADBEEF from that cycle onward; value holds after a following write to 0x0020.
- Aliasing: write 0x12345678 to 0x0405, then read 0x0005 -> MDataOut=0x12345678.
- Strobe during WAIT: write to 0x0001, then strobe a read to 0x0002 at cycle 2 -> ProtoErr=1; only the write completes (one MReady); a later read of 0x0002 shows it was not written.
- Reset mid-write: write 0xAAAA5555 to 0x0030 over old value 0x11111111, assert reset at cycle 3 -> all outputs 0; no MReady; a subsequent read of 0x0030 returns 0x11111111.
- WAIT_CYCLES=0 build, back-to-back requests with MStrobe held high: write then read of 0x0007 -> MReady in cycle 2 after each capture; one IDLE cycle between requests; read returns the written data.

Source files
------------

// File: rtl/main_memory_port.sv
// Wait-stated main memory behind the cache controller: captures one request per
// strobe, waits WAIT_CYCLES, performs the array access, then pulses MReady.
module main_memory_port #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              Busy,
    output logic              ProtoErr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    // Encoding chosen so Busy and MReady are each a single state bit.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b11
    } state_t;

    state_t                  state, state_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic                    rw_q;
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [DATA_W-1:0]       data_q;
    logic                    capture;
    logic                    access;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        access    = 1'b0;
        case (state)
            S_IDLE: begin
                if (MStrobe) begin
                    capture   = 1'b1;
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    access    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            MDataOut <= '0;
            ProtoErr <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                rw_q   <= MRW;
                addr_q <= MAddr[DEPTH_LOG2-1:0];
                data_q <= MDataIn;
            end
            if (access && !rw_q)
                MDataOut <= mem[addr_q];
            if (MStrobe && state != S_IDLE)
                ProtoErr <= 1'b1;
        end
    end

    // Array is deliberately not reset; an aborted request never reaches access.
    always_ff @(posedge clk) begin
        if (access && rw_q)
            mem[addr_q] <= data_q;
    end

    assign Busy   = state[0];
    assign MReady = state[1];

endmodule

// File: tb/tb_main_memory_port.sv
// Directed bench for main_memory_port: a WAIT_CYCLES=4 instance driven from a
// transaction table plus corner sequences, and a WAIT_CYCLES=0 instance.
module tb_main_memory_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        strobe = 1'b0, rw = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        ready, busy, perr;

    logic        strobe0 = 1'b0, rw0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [31:0] din0 = '0;
    logic [31:0] dout0;
    logic        ready0, busy0, perr0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    main_memory_port #(.DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr),
        .MDataIn(din), .MDataOut(dout), .MReady(ready), .Busy(busy), .ProtoErr(perr)
    );

    main_memory_port #(.DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MStrobe(strobe0), .MRW(rw0), .MAddr(addr0),
        .MDataIn(din0), .MDataOut(dout0), .MReady(ready0), .Busy(busy0), .ProtoErr(perr0)
    );

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on the WAIT_CYCLES=4 instance; MReady expected in cycle 6.
    task automatic run_req(input string name, input logic r, input logic [15:0] a,
                           input logic [31:0] d, input logic [31:0] exp_dout,
                           input logic exp_perr);
        int rdy_cnt, rdy_at, busy_cnt;
        logic [31:0] dout_at;
        rdy_cnt = 0; rdy_at = 0; busy_cnt = 0; dout_at = '0;
        @(negedge clk);
        strobe = 1'b1; rw = r; addr = a; din = d;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                strobe = 1'b0; rw = ~r; addr = 16'hFFFF; din = 32'h0;
            end
            if (ready) begin
                rdy_cnt++;
                if (rdy_at == 0) begin
                    rdy_at = k;
                    dout_at = dout;
                end
            end
            if (busy) busy_cnt++;
        end
        check({name, " ready_cycle"}, 32'(rdy_at), 32'd6);
        check({name, " ready_pulses"}, 32'(rdy_cnt), 32'd1);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'd6);
        check({name, " dout_at_ready"}, dout_at, exp_dout);
        check({name, " dout_after"}, dout, exp_dout);
        check({name, " proto_err"}, 32'(perr), 32'(exp_perr));
    endtask

    initial begin
        int rdy_cnt, rdy_at, busy_cnt;
        logic [6:0] rdy_v, busy_v;
        logic [31:0] d0_k2, d0_k5;

        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b0, 16'h0010, 32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 16'h0020, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 16'h0405, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 16'h0005, 32'h00000000, 32'h12345678};
        vecs[5] = '{1'b1, 16'h0002, 32'h0BADC0DE, 32'h12345678};
        vecs[6] = '{1'b1, 16'h0030, 32'h11111111, 32'h12345678};
        vecs[7] = '{1'b0, 16'h0020, 32'h00000000, 32'hCAFEF00D};

        repeat (2) @(negedge clk);
        check("reset dout", dout, 32'h0);
        check("reset ready", 32'(ready), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset perr", 32'(perr), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].din,
                    vecs[i].dout, 1'b0);

        // Read strobe during WAIT of a write: ignored, flags ProtoErr.
        rdy_cnt = 0; rdy_at = 0;
        @(negedge clk);
        strobe = 1'b1; rw = 1'b1; addr = 16'h0001; din = 32'h00000055;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready) begin
                rdy_cnt++;
                if (rdy_at == 0) rdy_at = k;
            end
            if (k == 1) strobe = 1'b0;
            if (k == 2) begin strobe = 1'b1; rw = 1'b0; addr = 16'h0002; end
            if (k == 3) strobe = 1'b0;
        end
        check("proto ready_pulses", 32'(rdy_cnt), 32'd1);
        check("proto ready_cycle", 32'(rdy_at), 32'd6);
        check("proto perr", 32'(perr), 32'd1);
        check("proto dout_held", dout, 32'hCAFEF00D);
        run_req("proto rd1", 1'b0, 16'h0001, 32'h0, 32'h00000055, 1'b1);
        run_req("proto rd2", 1'b0, 16'h0002, 32'h0, 32'h0BADC0DE, 1'b1);

        // Reset partway through a write: nothing committed, no MReady.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        rdy_cnt = 0; busy_cnt = 0;
        strobe = 1'b1; rw = 1'b1; addr = 16'h0030; din = 32'hAAAA5555;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready) rdy_cnt++;
            if (k == 1) strobe = 1'b0;
            if (k == 3) begin
                reset = 1'b1;
                #1;
                check("midrst dout", dout, 32'h0);
                check("midrst ready", 32'(ready), 32'h0);
                check("midrst busy", 32'(busy), 32'h0);
                check("midrst perr", 32'(perr), 32'h0);
            end
            if (k == 4) reset = 1'b0;
            if (k > 4 && busy) busy_cnt++;
        end
        check("midrst ready_pulses", 32'(rdy_cnt), 32'd0);
        check("midrst idle_after", 32'(busy_cnt), 32'd0);
        run_req("midrst rd30", 1'b0, 16'h0030, 32'h0, 32'h11111111, 1'b0);

        // WAIT_CYCLES=0: strobe held across a write then a read of 0x0007.
        rdy_v = '0; busy_v = '0; d0_k2 = '1; d0_k5 = '0;
        @(negedge clk);
        strobe0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0007; din0 = 32'h00000077;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            rdy_v[k-1] = ready0;
            busy_v[k-1] = busy0;
            if (k == 2) d0_k2 = dout0;
            if (k == 5) d0_k5 = dout0;
            if (k == 1) begin rw0 = 1'b0; din0 = 32'hFFFFFFFF; end
            if (k == 5) strobe0 = 1'b0;
        end
        check("w0 ready_pattern", 32'(rdy_v), 32'(7'b0010010));
        check("w0 busy_pattern", 32'(busy_v), 32'(7'b0011011));
        check("w0 dout_after_write", d0_k2, 32'h0);
        check("w0 dout_read", d0_k5, 32'h00000077);
        check("w0 dout_held", dout0, 32'h00000077);
        check("w0 perr_held_strobe", 32'(perr0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
